// File: rtl/cordic_pkg.sv
// Shared definitions for cordic_scale users: default tag/id widths and helpers
// that build and split the {tag, id} side-band code carried through the pipeline.
package cordic_pkg;

    localparam int DEF_ID_W   = 2;
    localparam int DEF_TAG_W  = 6;
    localparam int CODE_WIDTH = DEF_TAG_W + DEF_ID_W;

    function automatic logic [CODE_WIDTH-1:0] pack_code(input logic [DEF_TAG_W-1:0] tag,
                                                        input logic [DEF_ID_W-1:0]  id);
        return {tag, id};
    endfunction

    function automatic logic [DEF_ID_W-1:0] code_id(input logic [CODE_WIDTH-1:0] code);
        return code[DEF_ID_W-1:0];
    endfunction

    function automatic logic [DEF_TAG_W-1:0] code_tag(input logic [CODE_WIDTH-1:0] code);
        return code[CODE_WIDTH-1:DEF_ID_W];
    endfunction

endpackage

// File: rtl/cordic_scale_arbiter_if.sv
// Bus bundle of the arbiter: requester side, pipeline issue/return and response channel.
// slave is the arbiter's view, master the surrounding environment's view.
interface cordic_scale_arbiter_if #(
    parameter int WIDTH = 16,
    parameter int N_REQ = 4,
    parameter int ID_W  = 2,
    parameter int TAG_W = 6
);
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*WIDTH-1:0] req_value;
    logic [N_REQ*TAG_W-1:0] req_tag;

    logic [WIDTH-1:0]       pipe_value;
    logic [TAG_W+ID_W-1:0]  pipe_code;
    logic                   pipe_valid;

    logic [WIDTH-1:0]       ret_value;
    logic [TAG_W+ID_W-1:0]  ret_code;
    logic                   ret_valid;

    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [WIDTH-1:0]       rsp_value;
    logic [ID_W-1:0]        rsp_id;
    logic [TAG_W-1:0]       rsp_tag;
    logic                   ovf_err;

    modport slave (
        input  req_valid, req_value, req_tag, ret_value, ret_code, ret_valid, rsp_ready,
        output req_ready, pipe_value, pipe_code, pipe_valid,
               rsp_valid, rsp_value, rsp_id, rsp_tag, ovf_err
    );

    modport master (
        output req_valid, req_value, req_tag, ret_value, ret_code, ret_valid, rsp_ready,
        input  req_ready, pipe_value, pipe_code, pipe_valid,
               rsp_valid, rsp_value, rsp_id, rsp_tag, ovf_err
    );

endinterface

// File: rtl/cordic_scale_arbiter_sync_fifo.sv
// Single-clock result FIFO. A push into a full FIFO is taken only when a pop
// happens in the same cycle; the storage array itself carries no reset.
module sync_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // pointer and occupancy bookkeeping
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // storage write
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/cordic_scale_arbiter.sv
// Shares one fixed-latency cordic_scale pipeline between N_REQ requesters.
// Round-robin issue, result FIFO on the return path, and a credit counter that
// only admits a request when a FIFO slot is guaranteed for its result.
module cordic_scale_arbiter
    import cordic_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int N_REQ      = 4,
    parameter int ID_W       = DEF_ID_W,
    parameter int TAG_W      = DEF_TAG_W,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    cordic_scale_arbiter_if.slave bus
);
    localparam int CODE_W = TAG_W + ID_W;
    localparam int CW     = $clog2(FIFO_DEPTH) + 1;

    logic [CW-1:0]        credits;
    logic [ID_W-1:0]      ptr;
    logic [N_REQ-1:0]     grant;
    logic [ID_W-1:0]      grant_id;
    logic                 grant_any;
    int                   idx;

    logic [WIDTH-1:0]     pipe_value_p0;
    logic [CODE_W-1:0]    pipe_code_p0;
    logic                 vld_p0;

    logic [WIDTH+CODE_W-1:0] fifo_rdata;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 rsp_pop;
    logic                 ovf_q;

    // round-robin search starting after the last granted requester, gated by credits
    always_comb begin
        grant     = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        idx       = 0;
        if (credits != '0) begin
            for (int k = 1; k <= N_REQ; k++) begin
                idx = (int'(ptr) + k) % N_REQ;
                if (!grant_any && bus.req_valid[idx]) begin
                    grant_any  = 1'b1;
                    grant[idx] = 1'b1;
                    grant_id   = ID_W'(idx);
                end
            end
        end
    end

    assign bus.req_ready = grant & {N_REQ{reset_n}};
    assign rsp_pop       = !fifo_empty && bus.rsp_ready;

    // credits: one consumed per issue, one returned per delivered response
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            credits <= CW'(FIFO_DEPTH);
            ptr     <= ID_W'(N_REQ - 1);
        end else begin
            if (grant_any) ptr <= grant_id;
            case ({grant_any, rsp_pop})
                2'b10:   credits <= credits - 1'b1;
                2'b01:   credits <= credits + 1'b1;
                default: credits <= credits;
            endcase
        end
    end

    // issue stage: register the granted request towards the pipeline
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_p0        <= 1'b0;
            pipe_value_p0 <= '0;
            pipe_code_p0  <= '0;
        end else begin
            vld_p0 <= grant_any;
            if (grant_any) begin
                pipe_value_p0 <= bus.req_value[int'(grant_id)*WIDTH +: WIDTH];
                pipe_code_p0  <= {bus.req_tag[int'(grant_id)*TAG_W +: TAG_W], grant_id};
            end
        end
    end

    assign bus.pipe_valid = vld_p0;
    assign bus.pipe_value = pipe_value_p0;
    assign bus.pipe_code  = pipe_code_p0;

    sync_fifo #(
        .WIDTH (WIDTH + CODE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (bus.ret_valid),
        .wdata   ({bus.ret_code, bus.ret_value}),
        .pop     (rsp_pop),
        .rdata   (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // a return that finds the FIFO full with no pop is lost; flag it until reset
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q <= 1'b0;
        end else if (bus.ret_valid && fifo_full && !rsp_pop) begin
            ovf_q <= 1'b1;
        end
    end

    assign bus.ovf_err   = ovf_q;
    assign bus.rsp_valid = !fifo_empty;
    assign bus.rsp_value = fifo_rdata[WIDTH-1:0];
    assign bus.rsp_id    = fifo_rdata[WIDTH +: ID_W];
    assign bus.rsp_tag   = fifo_rdata[WIDTH+ID_W +: TAG_W];

endmodule

// File: tb/tb_cordic_scale_arbiter.sv
// Bench for cordic_scale_arbiter: a 13-cycle cordic_scale stand-in on the pipe
// side, a request/grant reference model feeding an expected-response queue,
// and an independent monitor draining that queue against the response channel.
module tb_cordic_scale_arbiter;
    import cordic_pkg::*;

    localparam int WIDTH = 16;
    localparam int N_REQ = 4;
    localparam int ID_W  = 2;
    localparam int TAG_W = 6;
    localparam int DEPTH = 16;
    localparam int LAT   = 13;
    localparam int CW    = TAG_W + ID_W;

    logic clock   = 1'b0;
    logic reset_n = 1'b1;
    logic inject  = 1'b0;

    always #5 clock = ~clock;

    cordic_scale_arbiter_if #(.WIDTH(WIDTH), .N_REQ(N_REQ), .ID_W(ID_W), .TAG_W(TAG_W)) bus ();

    cordic_scale_arbiter #(
        .WIDTH(WIDTH), .N_REQ(N_REQ), .ID_W(ID_W), .TAG_W(TAG_W), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // cordic_scale gain: K ~= 311/512, arithmetic shift
    function automatic logic [WIDTH-1:0] scale(input logic [WIDTH-1:0] v);
        int p;
        p = int'($signed(v)) * 311;
        return WIDTH'(p >>> 9);
    endfunction

    // cordic_scale stand-in: 13-cycle delay line with the gain applied
    logic [LAT-1:0]   pv;
    logic [WIDTH-1:0] pval  [LAT];
    logic [CW-1:0]    pcode [LAT];

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pv <= '0;
        end else begin
            pv       <= {pv[LAT-2:0], bus.pipe_valid};
            pval[0]  <= scale(bus.pipe_value);
            pcode[0] <= bus.pipe_code;
            for (int i = 1; i < LAT; i++) begin
                pval[i]  <= pval[i-1];
                pcode[i] <= pcode[i-1];
            end
        end
    end

    assign bus.ret_valid = pv[LAT-1] | inject;
    assign bus.ret_value = pval[LAT-1];
    assign bus.ret_code  = pcode[LAT-1];

    typedef struct {
        logic [WIDTH-1:0] v;
        logic [ID_W-1:0]  id;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t q[$];
    int   credits_m;
    int   ptr_m;
    int   cyc      = 0;
    int   dut_hs   = 0;
    int   idle_dut = 0;
    int   phase    = 0;
    int   g;
    int   idx;
    bit   prev_hs  = 1'b0;
    logic [WIDTH-1:0] prev_val;
    logic [CW-1:0]    prev_code;
    logic [N_REQ-1:0] exp_ready;
    logic [WIDTH-1:0] mv;
    logic [TAG_W-1:0] mt;

    // reference model: expected grant each cycle, issued data, response queue
    always @(negedge clock) begin
        cyc++;
        if (!reset_n) begin
            credits_m = DEPTH;
            ptr_m     = N_REQ - 1;
            prev_hs   = 1'b0;
            q.delete();
            check("rst_req_ready", 32'(bus.req_ready), 32'd0);
            check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
            check("rst_ovf_err", 32'(bus.ovf_err), 32'd0);
            check("rst_pipe_valid", 32'(bus.pipe_valid), 32'd0);
        end else begin
            if (prev_hs) begin
                check("pipe_valid", 32'(bus.pipe_valid), 32'd1);
                check("pipe_value", 32'(bus.pipe_value), 32'(prev_val));
                check("pipe_code", 32'(bus.pipe_code), 32'(prev_code));
            end else begin
                check("pipe_idle", 32'(bus.pipe_valid), 32'd0);
            end
            g = -1;
            exp_ready = '0;
            if (credits_m > 0) begin
                for (int k = 1; k <= N_REQ; k++) begin
                    idx = (ptr_m + k) % N_REQ;
                    if (g < 0 && bus.req_valid[idx]) g = idx;
                end
            end
            if (g >= 0) exp_ready[g] = 1'b1;
            check("grant", 32'(bus.req_ready), 32'(exp_ready));
            if (|(bus.req_valid & bus.req_ready)) dut_hs++;
            if (phase == 2 && bus.req_ready == '0) idle_dut++;
            prev_hs = (g >= 0);
            if (g >= 0) begin
                mv = bus.req_value[g*WIDTH +: WIDTH];
                mt = bus.req_tag[g*TAG_W +: TAG_W];
                prev_val  = mv;
                prev_code = pack_code(mt, ID_W'(g));
                q.push_back('{scale(mv), ID_W'(g), mt});
                ptr_m = g;
                credits_m--;
            end
            if (bus.rsp_valid && bus.rsp_ready) credits_m++;
        end
    end

    exp_t e;

    // monitor: every delivered response must match the oldest expectation
    always @(negedge clock) begin
        if (reset_n && bus.rsp_valid && bus.rsp_ready) begin
            if (q.size() == 0) begin
                check("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                check("rsp_value", 32'(bus.rsp_value), 32'(e.v));
                check("rsp_id", 32'(bus.rsp_id), 32'(e.id));
                check("rsp_tag", 32'(bus.rsp_tag), 32'(e.tag));
            end
        end
    end

    task automatic rand_data();
        for (int i = 0; i < N_REQ; i++) begin
            bus.req_value[i*WIDTH +: WIDTH] = WIDTH'($urandom);
            bus.req_tag[i*TAG_W +: TAG_W]   = TAG_W'($urandom);
        end
    endtask

    task automatic single(input int id, input logic [WIDTH-1:0] val, input logic [TAG_W-1:0] tag,
                          input logic [WIDTH-1:0] expv, input logic [CW-1:0] expc);
        int hs;
        bit got;
        @(posedge clock); #1;
        bus.req_value[id*WIDTH +: WIDTH] = val;
        bus.req_tag[id*TAG_W +: TAG_W]   = tag;
        bus.req_valid     = '0;
        bus.req_valid[id] = 1'b1;
        @(negedge clock); #1;
        hs = cyc;
        check("single_ready", 32'(bus.req_ready[id]), 32'd1);
        @(posedge clock); #1;
        bus.req_valid = '0;
        check("single_pipe_valid", 32'(bus.pipe_valid), 32'd1);
        check("single_pipe_value", 32'(bus.pipe_value), 32'(val));
        check("single_pipe_code", 32'(bus.pipe_code), 32'(expc));
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clock); #1;
            got = bus.rsp_valid;
        end
        check("single_rsp_seen", 32'(got), 32'd1);
        check("single_latency", 32'(cyc - hs), 32'd15);
        check("single_rsp_value", 32'(bus.rsp_value), 32'(expv));
        check("single_rsp_id", 32'(bus.rsp_id), 32'(id));
        check("single_rsp_tag", 32'(bus.rsp_tag), 32'(tag));
    endtask

    int h0;

    initial begin
        bus.req_valid = '1;
        bus.req_value = '0;
        bus.req_tag   = '0;
        bus.rsp_ready = 1'b1;
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        bus.req_valid = '0;
        reset_n = 1'b1;

        // single request, latency and exact scaled value
        single(0, 16'd4096, 6'd5, 16'd2488, 8'h14);

        // fairness with everybody requesting and a free-running consumer
        @(posedge clock); #1;
        phase = 2;
        bus.req_valid = '1;
        repeat (40) begin
            rand_data();
            @(posedge clock); #1;
        end
        phase = 0;
        check("fair_idle_cycles", 32'(idle_dut), 32'd0);
        bus.req_valid = '0;
        repeat (40) @(posedge clock);
        #1;

        // credit exhaustion, then one pop buys exactly one grant
        bus.rsp_ready = 1'b0;
        bus.req_valid = '1;
        h0 = dut_hs;
        repeat (40) begin
            rand_data();
            @(posedge clock); #1;
        end
        check("credit_handshakes", 32'(dut_hs - h0), 32'd16);
        bus.rsp_ready = 1'b1;
        @(posedge clock); #1;
        bus.rsp_ready = 1'b0;
        h0 = dut_hs;
        repeat (25) @(posedge clock);
        #1;
        check("credit_one_more", 32'(dut_hs - h0), 32'd1);
        check("ovf_before", 32'(bus.ovf_err), 32'd0);

        // extra return into a full FIFO is dropped and flagged
        inject = 1'b1;
        @(posedge clock); #1;
        inject = 1'b0;
        @(posedge clock); #1;
        check("ovf_set", 32'(bus.ovf_err), 32'd1);
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        repeat (40) @(posedge clock);
        #1;
        check("ovf_sticky", 32'(bus.ovf_err), 32'd1);

        // issue and pop in the same cycle at credits==1
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'b0010;
        for (int i = 0; i < 40; i++) begin
            rand_data();
            @(posedge clock); #1;
            if (credits_m == 1) break;
        end
        bus.req_valid = '0;
        repeat (20) @(posedge clock);
        #1;
        h0 = dut_hs;
        bus.req_valid = '1;
        bus.rsp_ready = 1'b1;
        @(negedge clock); #1;
        @(negedge clock); #1;
        check("simul_grants", 32'(dut_hs - h0), 32'd2);
        @(posedge clock); #1;
        bus.req_valid = '0;
        repeat (40) @(posedge clock);

        // most negative input
        single(2, 16'h8000, 6'h2A, 16'hB240, 8'hAA);
        repeat (5) @(posedge clock);
        #1;

        // randomized traffic with a reset in the middle of a burst
        for (int n = 0; n < 300; n++) begin
            rand_data();
            bus.req_valid = N_REQ'($urandom);
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            if (n == 150) begin
                reset_n = 1'b0;
                repeat (2) @(posedge clock);
                #1;
                reset_n = 1'b1;
                bus.req_valid = '1;
                @(negedge clock); #1;
                check("post_reset_grant", 32'(bus.req_ready), 32'h1);
                check("post_reset_ovf", 32'(bus.ovf_err), 32'd0);
            end
            @(posedge clock); #1;
        end

        // drain everything that is still owed
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 100 && q.size() != 0; i++) @(posedge clock);
        #1;
        check("drain_empty", 32'(q.size()), 32'd0);
        @(negedge clock); #1;
        check("final_rsp_valid", 32'(bus.rsp_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
